// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: ALUOp encodings, datapath width and the decoded control bundle
// carried by ID/EX, EX/MEM and MEM/WB.
package id_ex_stage_pkg;

    localparam int PIPE_DW = 32;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    jump;
        logic    branch;
        logic    mem_read;
        logic    mem_to_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX stage; master drives ID, slave is the stage.
interface id_ex_stage_if #(
    parameter int DW   = 32,
    parameter int CNTW = 16
);
    logic            hold;
    logic            flush;
    logic            RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]      ALUOp;
    logic [DW-1:0]   id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]      id_rs, id_rt, id_rd;
    logic [5:0]      id_funct;

    logic            ex_RegDst, ex_Jump, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite;
    logic            ex_ALUSrc, ex_RegWrite;
    logic [1:0]      ex_ALUOp;
    logic [DW-1:0]   ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]      ex_rs, ex_rt, ex_rd;
    logic [5:0]      ex_funct;
    logic            ex_valid;
    logic            pc_write;
    logic            ifid_write;
    logic [CNTW-1:0] bubble_count;

    modport master (
        output hold, flush, RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
               ALUOp, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
        input  ex_RegDst, ex_Jump, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
               ex_RegWrite, ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_funct, ex_valid, pc_write, ifid_write, bubble_count
    );

    modport slave (
        input  hold, flush, RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
               ALUOp, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
        output ex_RegDst, ex_Jump, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
               ex_RegWrite, ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_funct, ex_valid, pc_write, ifid_write, bubble_count
    );
endinterface

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use detector and PC / IF-ID write enables; purely combinational.
module hazard_unit (
    input  logic       hold,
    input  logic       flush,
    input  logic       ex_mem_read,
    input  logic       ex_valid,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       luse,
    output logic       pc_write,
    output logic       ifid_write
);
    // rt match is taken even for I-type consumers: a spare bubble is cheaper than decoding here
    assign luse = ex_mem_read & ex_valid & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

    // A flushed ID instruction is discarded, so its hazard must not stall fetch
    assign pc_write   = ~(hold | (luse & ~flush));
    assign ifid_write = pc_write;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-cycle ID->EX, bubble on flush or load-use, frozen on hold,
// saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW   = PIPE_DW,
    parameter int CNTW = 16
) (
    input  logic        clk,
    input  logic        reset,
    id_ex_stage_if.slave bus
);
    ctrl_t           ctrl_q;
    ctrl_t           id_ctrl;
    logic            valid_q;
    logic [DW-1:0]   pc4_q, rd1_q, rd2_q, imm_q;
    logic [4:0]      rs_q, rt_q, rd_q;
    logic [5:0]      funct_q;
    logic [CNTW-1:0] cnt_q;
    logic            luse;
    logic            bubble;

    assign id_ctrl = '{
        reg_dst:    bus.RegDst,
        jump:       bus.Jump,
        branch:     bus.Branch,
        mem_read:   bus.MemRead,
        mem_to_reg: bus.MemtoReg,
        mem_write:  bus.MemWrite,
        alu_src:    bus.ALUSrc,
        reg_write:  bus.RegWrite,
        alu_op:     alu_op_e'(bus.ALUOp)
    };

    hazard_unit u_hazard (
        .hold        (bus.hold),
        .flush       (bus.flush),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_valid    (valid_q),
        .ex_rt       (rt_q),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .luse        (luse),
        .pc_write    (bus.pc_write),
        .ifid_write  (bus.ifid_write)
    );

    assign bubble = bus.flush | luse;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= CTRL_NOP;
            valid_q <= 1'b0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
            cnt_q   <= '0;
        end else if (!bus.hold) begin
            // Data fields load even on a bubble so the slot content stays deterministic
            pc4_q   <= bus.id_pc4;
            rd1_q   <= bus.id_rd1;
            rd2_q   <= bus.id_rd2;
            imm_q   <= bus.id_imm;
            rs_q    <= bus.id_rs;
            rt_q    <= bus.id_rt;
            rd_q    <= bus.id_rd;
            funct_q <= bus.id_funct;
            if (bubble) begin
                ctrl_q  <= CTRL_NOP;
                valid_q <= 1'b0;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNTW'(1);
                end
            end else begin
                ctrl_q  <= id_ctrl;
                valid_q <= 1'b1;
            end
        end
    end

    assign bus.ex_RegDst    = ctrl_q.reg_dst;
    assign bus.ex_Jump      = ctrl_q.jump;
    assign bus.ex_Branch    = ctrl_q.branch;
    assign bus.ex_MemRead   = ctrl_q.mem_read;
    assign bus.ex_MemtoReg  = ctrl_q.mem_to_reg;
    assign bus.ex_MemWrite  = ctrl_q.mem_write;
    assign bus.ex_ALUSrc    = ctrl_q.alu_src;
    assign bus.ex_RegWrite  = ctrl_q.reg_write;
    assign bus.ex_ALUOp     = ctrl_q.alu_op;
    assign bus.ex_pc4       = pc4_q;
    assign bus.ex_rd1       = rd1_q;
    assign bus.ex_rd2       = rd2_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_rs        = rs_q;
    assign bus.ex_rt        = rt_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_funct     = funct_q;
    assign bus.ex_valid     = valid_q;
    assign bus.bubble_count = cnt_q;
endmodule
